acc_cpu_param: RTL and testbench

- Parametrised successor to the team's 6-bit two-register microcoded CPU.
- Same accumulator model: A, B, PC, and a per-instruction micro-sequencer over a single external memory word bus.
- Adds:
  - generic data and address widths
  - a 16-entry ISA with ALU ops, carry flag, and memory load/store
  - an output port, a run/stall input and a halt state
- Sits between the chip IO wrapper and an external (combinational-read) program/data memory.

---
 rtl/acc_cpu_param.sv | 173 +++++++++++++++++
 tb/tb_acc_cpu_param.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_cpu_param.sv
// acc_cpu_param -- parametrised accumulator CPU with a micro-sequenced datapath.
//
// Registers A, B, PC, carry flag C, a 4-bit instruction register and an
// operand-address latch. Each instruction is fetched in one step and executed
// in a second one. LD/ST need a third step to access data memory. HLT parks
// the core in an absorbing HALT state that only reset leaves.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   run        1 = advance one micro-step per clock, 0 = hold every register
//   mem_addr   memory address (PC, or latched operand address during MEM)
//   mem_rdata  combinational memory read data for mem_addr
//   mem_wdata  store data, always equal to A
//   mem_we     one-cycle write strobe during the MEM step of ST
//   out_port   registered output, loaded by OUT
//   halted     set by HLT, cleared only by reset
module acc_cpu_param #(
   parameter int DATA_W   = 6,
   parameter int ADDR_W   = 6,
   parameter int RESET_PC = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic [DATA_W-1:0] out_port,
   output logic              halted
);

   typedef enum logic [1:0] {ST_FETCH, ST_EXEC, ST_MEM, ST_HALT} state_t;

   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_SWAP = 4'd2;
   localparam logic [3:0] OP_JMP  = 4'd3;
   localparam logic [3:0] OP_JZ   = 4'd4;
   localparam logic [3:0] OP_LDI  = 4'd5;
   localparam logic [3:0] OP_SUB  = 4'd6;
   localparam logic [3:0] OP_AND  = 4'd7;
   localparam logic [3:0] OP_XOR  = 4'd8;
   localparam logic [3:0] OP_OUT  = 4'd9;
   localparam logic [3:0] OP_JC   = 4'd10;
   localparam logic [3:0] OP_HLT  = 4'd11;
   localparam logic [3:0] OP_ST   = 4'd12;
   localparam logic [3:0] OP_LD   = 4'd13;
   localparam logic [3:0] OP_INC  = 4'd14;

   state_t            state_reg, state_next;
   logic [DATA_W-1:0] a_reg, a_next;
   logic [DATA_W-1:0] b_reg, b_next;
   logic              c_reg, c_next;
   logic [ADDR_W-1:0] pc_reg, pc_next;
   logic [3:0]        ir_reg, ir_next;
   logic [ADDR_W-1:0] opr_reg, opr_next;
   logic [DATA_W-1:0] out_reg, out_next;
   logic              halted_reg, halted_next;

   logic [ADDR_W-1:0] operand_addr;
   logic [ADDR_W-1:0] pc_inc;
   logic [DATA_W:0]   add_res;
   logic [DATA_W:0]   sub_res;
   logic [DATA_W:0]   inc_res;

   // Operand word seen as an address: truncated or zero-extended.
   generate
      if (ADDR_W <= DATA_W) begin : g_addr_trunc
         assign operand_addr = mem_rdata[ADDR_W-1:0];
      end else begin : g_addr_zext
         assign operand_addr = {{(ADDR_W-DATA_W){1'b0}}, mem_rdata};
      end
   endgenerate

   assign pc_inc  = pc_reg + 1'b1;
   assign add_res = {1'b0, a_reg} + {1'b0, b_reg};
   // Top bit of the extended difference is the borrow.
   assign sub_res = {1'b0, a_reg} - {1'b0, b_reg};
   assign inc_res = {1'b0, a_reg} + 1'b1;

   assign mem_addr  = (state_reg == ST_MEM) ? opr_reg : pc_reg;
   assign mem_wdata = a_reg;
   assign mem_we    = run && (state_reg == ST_MEM) && (ir_reg == OP_ST);
   assign out_port  = out_reg;
   assign halted    = halted_reg;

   always_comb begin
      state_next  = state_reg;
      a_next      = a_reg;
      b_next      = b_reg;
      c_next      = c_reg;
      pc_next     = pc_reg;
      ir_next     = ir_reg;
      opr_next    = opr_reg;
      out_next    = out_reg;
      halted_next = halted_reg;

      if (run) begin
         case (state_reg)
            ST_FETCH: begin
               ir_next    = mem_rdata[3:0];
               pc_next    = pc_inc;
               state_next = ST_EXEC;
            end
            ST_EXEC: begin
               state_next = ST_FETCH;
               case (ir_reg)
                  OP_ADD:  {c_next, a_next} = add_res;
                  OP_SWAP: begin
                     a_next = b_reg;
                     b_next = a_reg;
                  end
                  OP_JMP:  pc_next = operand_addr;
                  OP_JZ:   pc_next = (a_reg == '0) ? operand_addr : pc_inc;
                  OP_LDI: begin
                     a_next  = mem_rdata;
                     pc_next = pc_inc;
                  end
                  OP_SUB:  {c_next, a_next} = sub_res;
                  OP_AND:  a_next = a_reg & b_reg;
                  OP_XOR:  a_next = a_reg ^ b_reg;
                  OP_OUT:  out_next = a_reg;
                  OP_JC:   pc_next = c_reg ? operand_addr : pc_inc;
                  OP_HLT: begin
                     halted_next = 1'b1;
                     state_next  = ST_HALT;
                  end
                  OP_ST, OP_LD: begin
                     opr_next   = operand_addr;
                     pc_next    = pc_inc;
                     state_next = ST_MEM;
                  end
                  OP_INC:  {c_next, a_next} = inc_res;
                  default: ;  // NOP and opcode 15
               endcase
            end
            ST_MEM: begin
               if (ir_reg == OP_LD) begin
                  a_next = mem_rdata;
               end
               state_next = ST_FETCH;
            end
            default: ;  // HALT is absorbing
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= ST_FETCH;
         a_reg      <= '0;
         b_reg      <= '0;
         c_reg      <= 1'b0;
         pc_reg     <= ADDR_W'(RESET_PC);
         ir_reg     <= '0;
         opr_reg    <= '0;
         out_reg    <= '0;
         halted_reg <= 1'b0;
      end else begin
         state_reg  <= state_next;
         a_reg      <= a_next;
         b_reg      <= b_next;
         c_reg      <= c_next;
         pc_reg     <= pc_next;
         ir_reg     <= ir_next;
         opr_reg    <= opr_next;
         out_reg    <= out_next;
         halted_reg <= halted_next;
      end
   end

endmodule

// File: tb/tb_acc_cpu_param.sv
// Directed testbench for acc_cpu_param (default widths 6/6, RESET_PC 0).
// A behavioural 64x6 memory with combinational read and clocked write sits on
// the memory bus. Stimulus changes on the falling edge; outputs are sampled
// on the falling edge (or 1 ns after an input change).
module tb_acc_cpu_param;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       run = 1'b1;
   logic [5:0] mem_addr;
   logic [5:0] mem_rdata;
   logic [5:0] mem_wdata;
   logic       mem_we;
   logic [5:0] out_port;
   logic       halted;

   logic [5:0] mem [64];
   int         checks = 0;
   int         failures = 0;
   int         we_count = 0;

   acc_cpu_param #(.DATA_W(6), .ADDR_W(6), .RESET_PC(0)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .run       (run),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .out_port  (out_port),
      .halted    (halted)
   );

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr];

   always @(posedge clk) begin
      if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
         we_count <= we_count + 1;
      end
   end

   // Assert reset on a falling edge and clear the memory.
   task automatic begin_reset();
      @(negedge clk);
      rst_n = 1'b0;
      run   = 1'b1;
      for (int i = 0; i < 64; i++) mem[i] = 6'd0;
      #1;
   endtask

   // Release reset on a falling edge; no rising edge has yet been seen with rst_n=1.
   task automatic end_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic run_until_halt(input int bound, output int cycles);
      cycles = 0;
      while (!halted && cycles < bound) begin
         @(negedge clk);
         cycles++;
      end
   endtask

   task automatic test_reset();
      begin_reset();
      checks++;
      if (mem_addr !== 6'd0 || out_port !== 6'd0 || halted !== 1'b0 || mem_we !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs: got addr=%0d out=%0d halted=%0b we=%0b required 0/0/0/0",
                  mem_addr, out_port, halted, mem_we);
      end
      end_reset();
      // PC advances once per two clocks: address after k clocks is (k+1)/2 mod 64.
      for (int k = 0; k <= 130; k++) begin
         checks++;
         if (mem_addr !== 6'(((k + 1) / 2) % 64) || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL nop_walk k=%0d: got addr=%0d we=%0b required addr=%0d we=0",
                     k, mem_addr, mem_we, ((k + 1) / 2) % 64);
         end
         @(negedge clk);
      end
      $display("test_reset: nop walk and wrap covered");
   endtask

   task automatic test_alu_out();
      int cyc;
      begin_reset();
      mem[0] = 6'd5;  mem[1] = 6'd5;   // LDI 5
      mem[2] = 6'd2;                   // SWAP
      mem[3] = 6'd5;  mem[4] = 6'd3;   // LDI 3
      mem[5] = 6'd1;                   // ADD
      mem[6] = 6'd9;                   // OUT
      mem[7] = 6'd11;                  // HLT
      end_reset();
      run_until_halt(40, cyc);
      checks++;
      if (cyc !== 12) begin
         failures++;
         $display("FAIL alu_halt_cycles: got %0d required 12", cyc);
      end
      checks++;
      if (out_port !== 6'd8) begin
         failures++;
         $display("FAIL alu_out: got %0d required 8", out_port);
      end
      repeat (6) @(negedge clk);
      checks++;
      if (mem_addr !== 6'd8 || halted !== 1'b1 || mem_we !== 1'b0) begin
         failures++;
         $display("FAIL alu_halt_hold: got addr=%0d halted=%0b we=%0b required 8/1/0",
                  mem_addr, halted, mem_we);
      end
      $display("test_alu_out: cycles=%0d out=%0d", cyc, out_port);
   endtask

   task automatic test_carry_jc(input logic [5:0] first, input logic [5:0] exp_out,
                                input logic [5:0] exp_addr, input int exp_cyc);
      int cyc;
      begin_reset();
      mem[0] = 6'd5;  mem[1] = first;  // LDI first
      mem[2] = 6'd2;                   // SWAP
      mem[3] = 6'd5;  mem[4] = 6'd1;   // LDI 1
      mem[5] = 6'd1;                   // ADD
      mem[6] = 6'd10; mem[7] = 6'd20;  // JC 20
      mem[8] = 6'd14;                  // INC
      mem[9] = 6'd9;                   // OUT
      mem[10] = 6'd11;                 // HLT
      mem[20] = 6'd9;                  // OUT
      mem[21] = 6'd11;                 // HLT
      end_reset();
      run_until_halt(60, cyc);
      checks++;
      if (cyc !== exp_cyc) begin
         failures++;
         $display("FAIL jc_cycles first=%0d: got %0d required %0d", first, cyc, exp_cyc);
      end
      checks++;
      if (out_port !== exp_out) begin
         failures++;
         $display("FAIL jc_out first=%0d: got %0d required %0d", first, out_port, exp_out);
      end
      checks++;
      if (mem_addr !== exp_addr) begin
         failures++;
         $display("FAIL jc_halt_pc first=%0d: got %0d required %0d", first, mem_addr, exp_addr);
      end
      $display("test_carry_jc: first=%0d out=%0d pc=%0d", first, out_port, mem_addr);
   endtask

   task automatic test_jz_loop();
      bit revisited = 0;
      begin_reset();
      mem[0] = 6'd1;                   // ADD
      mem[1] = 6'd2;                   // SWAP
      mem[2] = 6'd4;  mem[3] = 6'd0;   // JZ 0
      mem[4] = 6'd5;  mem[5] = 6'd63;  // LDI 63
      mem[6] = 6'd3;  mem[7] = 6'd6;   // JMP 6
      end_reset();
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         checks++;
         if (mem_addr > 6'd3 || halted !== 1'b0) begin
            failures++;
            $display("FAIL jz_loop_range k=%0d: got addr=%0d halted=%0b required addr<=3 halted=0",
                     k, mem_addr, halted);
         end
         if (k > 8 && mem_addr == 6'd0) revisited = 1;
      end
      checks++;
      if (revisited !== 1'b1) begin
         failures++;
         $display("FAIL jz_loop_return: got %0b required 1", revisited);
      end
      $display("test_jz_loop: loop confined to 0..3");
   endtask

   task automatic load_mem_program();
      mem[0] = 6'd5;  mem[1] = 6'd42;  // LDI 42
      mem[2] = 6'd12; mem[3] = 6'd50;  // ST 50
      mem[4] = 6'd5;  mem[5] = 6'd0;   // LDI 0
      mem[6] = 6'd13; mem[7] = 6'd50;  // LD 50
      mem[8] = 6'd9;                   // OUT
      mem[9] = 6'd11;                  // HLT
   endtask

   task automatic test_memory();
      int pulses = 0;
      int we_cyc = -1;
      logic [5:0] we_addr = '0;
      logic [5:0] we_data = '0;
      logic [5:0] ld_addr = '0;
      int cyc = 0;
      begin_reset();
      load_mem_program();
      end_reset();
      while (!halted && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (mem_we) begin
            pulses++;
            we_cyc  = cyc;
            we_addr = mem_addr;
            we_data = mem_wdata;
         end
         if (cyc == 9) ld_addr = mem_addr;
      end
      checks++;
      if (pulses !== 1 || we_cyc !== 4) begin
         failures++;
         $display("FAIL st_pulse: got pulses=%0d at cycle %0d required 1 at cycle 4", pulses, we_cyc);
      end
      checks++;
      if (we_addr !== 6'd50 || we_data !== 6'd42) begin
         failures++;
         $display("FAIL st_bus: got addr=%0d wdata=%0d required 50/42", we_addr, we_data);
      end
      checks++;
      if (ld_addr !== 6'd50) begin
         failures++;
         $display("FAIL ld_addr: got %0d required 50", ld_addr);
      end
      checks++;
      if (cyc !== 14 || out_port !== 6'd42 || mem[50] !== 6'd42) begin
         failures++;
         $display("FAIL ld_result: got cycles=%0d out=%0d mem50=%0d required 14/42/42",
                  cyc, out_port, mem[50]);
      end
      $display("test_memory: st at cycle %0d, out=%0d", we_cyc, out_port);
   endtask

   task automatic test_stall();
      int cyc;
      int base;
      begin_reset();
      load_mem_program();
      end_reset();
      repeat (4) @(negedge clk);   // now in MEM of ST
      base = we_count;
      run = 1'b0;
      #1;
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (mem_we !== 1'b0 || mem_addr !== 6'd50 || mem[50] !== 6'd0) begin
            failures++;
            $display("FAIL stall_hold k=%0d: got we=%0b addr=%0d mem50=%0d required 0/50/0",
                     k, mem_we, mem_addr, mem[50]);
         end
         if (k < 5) @(negedge clk);
      end
      run = 1'b1;
      #1;
      checks++;
      if (mem_we !== 1'b1) begin
         failures++;
         $display("FAIL stall_resume_we: got %0b required 1", mem_we);
      end
      run_until_halt(40, cyc);
      checks++;
      if (cyc !== 10 || out_port !== 6'd42 || mem[50] !== 6'd42 || we_count - base !== 1) begin
         failures++;
         $display("FAIL stall_result: got cycles=%0d out=%0d mem50=%0d pulses=%0d required 10/42/42/1",
                  cyc, out_port, mem[50], we_count - base);
      end
      $display("test_stall: resumed and halted after %0d cycles", cyc);
   endtask

   task automatic test_reset_mid();
      int cyc;
      begin_reset();
      checks++;
      if (halted !== 1'b0) begin
         failures++;
         $display("FAIL reset_over_halt: got %0b required 0", halted);
      end
      mem[0] = 6'd5;  mem[1] = 6'd9;   // LDI 9
      mem[2] = 6'd9;                   // OUT
      mem[3] = 6'd13; mem[4] = 6'd50;  // LD 50
      mem[5] = 6'd9;                   // OUT
      mem[6] = 6'd11;                  // HLT
      mem[50] = 6'd33;
      end_reset();
      repeat (5) @(negedge clk);       // EXEC of LD
      checks++;
      if (out_port !== 6'd9 || mem_addr !== 6'd4) begin
         failures++;
         $display("FAIL mid_pre: got out=%0d addr=%0d required 9/4", out_port, mem_addr);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_port !== 6'd0 || mem_addr !== 6'd0 || mem_we !== 1'b0 || halted !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset: got out=%0d addr=%0d we=%0b halted=%0b required 0/0/0/0",
                  out_port, mem_addr, mem_we, halted);
      end
      @(negedge clk);
      rst_n = 1'b1;
      run_until_halt(40, cyc);
      checks++;
      if (cyc !== 11 || out_port !== 6'd33) begin
         failures++;
         $display("FAIL mid_restart: got cycles=%0d out=%0d required 11/33", cyc, out_port);
      end
      $display("test_reset_mid: restart cycles=%0d out=%0d", cyc, out_port);
   endtask

   initial begin
      test_reset();
      test_alu_out();
      test_carry_jc(6'd63, 6'd0, 6'd22, 14);
      test_carry_jc(6'd0, 6'd2, 6'd11, 16);
      test_jz_loop();
      test_memory();
      test_stall();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
